// File: rtl/idl_pkg.sv
// -----------------------------------------------------------------------------
// idl_pkg
// Shared definitions for the 1-bit IDL lane (receiver and transmitter).
//   K_IDLE     idle comma, also the byte-alignment pattern
//   K_ACTIVE   active marker
//   rx_state_e receiver alignment FSM encoding
//   is_ctrl()  true for either control byte
// -----------------------------------------------------------------------------
package idl_pkg;

    localparam logic [7:0] K_IDLE   = 8'hBC;
    localparam logic [7:0] K_ACTIVE = 8'h7C;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        SYNCED = 2'd2
    } rx_state_e;

    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == K_IDLE) || (b == K_ACTIVE);
    endfunction

endpackage

// File: rtl/serialtopar_rx_if.sv
// -----------------------------------------------------------------------------
// serialtopar_rx_if
// Serial lane in / parallel bus out of the IDL receiver.
//   data_in     serial lane, MSB first
//   data_out    last received data byte
//   valid_out   one-cycle strobe, data_out carries a new data byte
//   active_out  1 after 0x7C, 0 after 0xBC
//   sync_out    1 while byte alignment is locked
// Modports: master = lane driver / bus consumer, slave = receiver.
// -----------------------------------------------------------------------------
interface serialtopar_rx_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_out;
    logic       sync_out;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active_out,
        input  sync_out
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active_out,
        output sync_out
    );

endinterface

// File: rtl/idl_deser8.sv
// -----------------------------------------------------------------------------
// idl_deser8
// Bit shifter and byte-phase counter for the IDL receiver.
//   clk_32f     in   bit clock
//   reset       in   asynchronous, active-low
//   bit_i       in   serial bit, MSB first
//   realign_i   in   restart the byte phase (bit count 0 on the next bit)
//   nxt_o       out  current byte window including the bit sampled this edge
//   boundary_o  out  this edge samples the 8th bit of a byte
// -----------------------------------------------------------------------------
module idl_deser8 (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       bit_i,
    input  logic       realign_i,
    output logic [7:0] nxt_o,
    output logic       boundary_o
);

    // Only the 7 most recent bits need storing; the 8th is the live input.
    logic [6:0] sr_q;
    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_d;

    assign nxt_o      = {sr_q, bit_i};
    assign boundary_o = (bit_cnt_q == 3'd7);
    assign bit_cnt_d  = realign_i ? 3'd0 : bit_cnt_q + 3'd1;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= nxt_o[6:0];
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/serialtopar_rx.sv
// -----------------------------------------------------------------------------
// serialtopar_rx
// Serial-to-parallel receiver for the 1-bit IDL lane. Finds byte alignment
// from repeated 0xBC commas, decodes 0xBC/0x7C control bytes and presents
// data bytes on a parallel bus with a one-cycle valid strobe.
//   clk_32f   in   bit clock, posedge
//   reset     in   asynchronous, active-low
//   rx        slave modport of serialtopar_rx_if (data_in, data_out,
//                  valid_out, active_out, sync_out)
// Parameters:
//   BC_LOCK     aligned commas needed to declare sync (1..15)
//   LOSS_BYTES  byte periods without a control byte before sync is dropped
// Optional feature macro: RX_LOSS_DET_EN (builds the loss-of-sync counter).
// -----------------------------------------------------------------------------
module serialtopar_rx
    import idl_pkg::*;
#(
    parameter int BC_LOCK    = 4,
    parameter int LOSS_BYTES = 16
) (
    input  logic              clk_32f,
    input  logic              reset,
    serialtopar_rx_if.slave   rx
);

    if (BC_LOCK < 1 || BC_LOCK > 15 || LOSS_BYTES < 1) begin : g_bad_param
        $error("serialtopar_rx: BC_LOCK must be 1..15 and LOSS_BYTES >= 1");
    end

    localparam logic [3:0] LOCK_N = 4'(BC_LOCK);

    logic [7:0] nxt;
    logic       boundary;
    logic       realign;

    rx_state_e  state_q, state_d;
    logic [3:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;

`ifdef RX_LOSS_DET_EN
    localparam int            LOSS_W    = $clog2(LOSS_BYTES + 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_BYTES - 1);
    logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
`endif

    idl_deser8 u_deser (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .bit_i      (rx.data_in),
        .realign_i  (realign),
        .nxt_o      (nxt),
        .boundary_o (boundary)
    );

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        active_d   = active_q;
        realign    = 1'b0;
`ifdef RX_LOSS_DET_EN
        loss_cnt_d = loss_cnt_q;
`endif
        unique case (state_q)
            SEARCH: begin
                // A comma anywhere in the bit stream fixes the byte phase.
                if (nxt == K_IDLE) begin
                    realign    = 1'b1;
                    byte_cnt_d = 4'd1;
                    state_d    = (BC_LOCK == 1) ? SYNCED : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (nxt == K_IDLE) begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        if (byte_cnt_d == LOCK_N) begin
                            state_d = SYNCED;
                        end
                    end else begin
                        // Not re-searched: the failing window cannot be a comma.
                        state_d    = SEARCH;
                        byte_cnt_d = '0;
                    end
                end
            end
            SYNCED: begin
                if (boundary) begin
                    if (nxt == K_IDLE) begin
                        active_d = 1'b0;
                    end else if (nxt == K_ACTIVE) begin
                        active_d = 1'b1;
                    end else begin
                        data_d  = nxt;
                        valid_d = 1'b1;
                    end
`ifdef RX_LOSS_DET_EN
                    // The byte that exhausts the budget is still delivered.
                    if (is_ctrl(nxt)) begin
                        loss_cnt_d = '0;
                    end else if (loss_cnt_q == LOSS_LAST) begin
                        state_d    = SEARCH;
                        active_d   = 1'b0;
                        loss_cnt_d = '0;
                    end else begin
                        loss_cnt_d = loss_cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q    <= SEARCH;
            byte_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
`ifdef RX_LOSS_DET_EN
            loss_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
`ifdef RX_LOSS_DET_EN
            loss_cnt_q <= loss_cnt_d;
`endif
        end
    end

    assign rx.data_out   = data_q;
    assign rx.valid_out  = valid_q;
    assign rx.active_out = active_q;
    assign rx.sync_out   = (state_q == SYNCED);

endmodule
